// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jk_pkg
// Description : Shared types and helpers for the JK excitation driver.
//               - FSM state encoding
//               - JK_HOLD constant (J=0, K=0)
//               - jk_excite(): per-bit excitation table, mapping (Q, T) to {J, K}
// Config      : JK_TOGGLE_EXCITE_EN -- when defined, a changing bit is driven
//               with toggle excitation (J=1, K=1) in both directions instead of
//               set/reset excitation.
// Revision    : 1.0 - initial release
// ============================================================================
package jk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXCITE = 2'd1,
      CHECK  = 2'd2
   } jk_state_e;

   localparam logic [1:0] JK_HOLD = 2'b00;

   // Returns {J, K} that moves a JK flip-flop from Q to T in one edge.
   // Don't-care table entries resolve to 0 to keep the excitation minimal.
   function automatic logic [1:0] jk_excite(input logic q, input logic t);
`ifdef JK_TOGGLE_EXCITE_EN
      return (q != t) ? 2'b11 : JK_HOLD;
`else
      if (!q && t) begin
         return 2'b10;
      end
      if (q && !t) begin
         return 2'b01;
      end
      return JK_HOLD;
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excitation_driver_bank.sv
`default_nettype none
// ============================================================================
// Module      : jk_reg_bank
// Description : W independent JK flip-flops sharing one clock.
//               Next state per bit: Q+ = J&~Q | ~K&Q.
//               A synchronous reset loads INIT.
// Ports       : clk     - rising-edge clock
//               rst     - synchronous reset, active-high
//               j_i     - J inputs, one per bit
//               k_i     - K inputs, one per bit
//               q_o     - bank state
//               q_bar_o - complement of the bank state
// Revision    : 1.0 - initial release
// ============================================================================
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int             W    = 4,
   parameter logic [W-1:0]   INIT = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] j_i,
   input  logic [W-1:0] k_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] q_bar_o
);

   logic [W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= INIT;
      end else begin
         q_q <= (j_i & ~q_q) | (~k_i & q_q);
      end
   end

   assign q_o     = q_q;
   assign q_bar_o = ~q_q;

endmodule
`default_nettype wire

// File: rtl/jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : jk_excitation_driver
// Description : Inverse JK flip-flop. Accepts target words over a valid/ready
//               stream and computes the per-bit J/K excitation that moves an
//               internal JK register bank from its current state to the target.
//               It then checks that the bank reached the target.
//               Each transaction takes three cycles: IDLE -> EXCITE -> CHECK.
// Config      : JK_TOGGLE_EXCITE_EN -- when defined, changing bits use toggle
//               excitation (J=K=1). When undefined, they use set/reset
//               excitation, and J=K=1 never appears.
// Ports       : clk       - rising-edge clock
//               rst       - synchronous reset, active-high
//               tgt_valid - target word offered
//               tgt_ready - block can accept a target (IDLE only)
//               tgt_data  - desired next Q
//               j_out     - registered J excitation applied to the bank
//               k_out     - registered K excitation applied to the bank
//               q         - JK bank state
//               q_bar     - ~q
//               done      - one-cycle pulse: bank matched the latched target
//               mismatch  - one-cycle pulse: bank differed from the target
//               chg_cnt   - saturating count of bits changed since reset
// Revision    : 1.0 - initial release
// ============================================================================
module jk_excitation_driver
   import jk_pkg::*;
#(
   parameter int             W    = 4,
   parameter logic [W-1:0]   INIT = {W{1'b1}},
   parameter int             CW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tgt_valid,
   output logic          tgt_ready,
   input  logic [W-1:0]  tgt_data,
   output logic [W-1:0]  j_out,
   output logic [W-1:0]  k_out,
   output logic [W-1:0]  q,
   output logic [W-1:0]  q_bar,
   output logic          done,
   output logic          mismatch,
   output logic [CW-1:0] chg_cnt
);

   // The adder is sized so that the counter plus a full-width popcount
   // cannot overflow before the saturation check.
   localparam int PW = $clog2(W + 1);
   localparam int SW = ((CW > PW) ? CW : PW) + 1;
   localparam logic [SW-1:0] CNT_MAX = SW'({CW{1'b1}});

   jk_state_e     state_q, state_d;
   logic [W-1:0]  j_q, j_d;
   logic [W-1:0]  k_q, k_d;
   logic [W-1:0]  tgt_q, tgt_d;
   logic          done_q, done_d;
   logic          mis_q, mis_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hs;
   logic [W-1:0]  diff;
   logic [SW-1:0] pop;
   logic [SW-1:0] cnt_sum;

   // --------------------------------------------------------------------
   // JK register bank. j_q/k_q are zero outside EXCITE, so the bank holds.
   // --------------------------------------------------------------------
   jk_reg_bank #(
      .W    (W),
      .INIT (INIT)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .j_i     (j_q),
      .k_i     (k_q),
      .q_o     (q),
      .q_bar_o (q_bar)
   );

   // --------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tgt_valid) state_d = EXCITE;
         EXCITE:  state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------
   always_comb begin
      tgt_ready = (state_q == IDLE);
      hs        = tgt_ready && tgt_valid;
   end

   // --------------------------------------------------------------------
   // Changed-bit popcount. This is evaluated in EXCITE, before the bank edge.
   // --------------------------------------------------------------------
   assign diff = q ^ tgt_q;

   always_comb begin
      pop = '0;
      for (int i = 0; i < W; i++) begin
         pop = pop + SW'(diff[i]);
      end
   end

   assign cnt_sum = SW'(cnt_q) + pop;

   // --------------------------------------------------------------------
   // Datapath next state
   // --------------------------------------------------------------------
   always_comb begin
      j_d    = '0;
      k_d    = '0;
      tgt_d  = tgt_q;
      done_d = 1'b0;
      mis_d  = 1'b0;
      cnt_d  = cnt_q;

      if (hs) begin
         tgt_d = tgt_data;
         for (int i = 0; i < W; i++) begin
            {j_d[i], k_d[i]} = jk_excite(q[i], tgt_data[i]);
         end
      end

      if (state_q == EXCITE) begin
         cnt_d = (cnt_sum > CNT_MAX) ? {CW{1'b1}} : cnt_sum[CW-1:0];
      end

      if (state_q == CHECK) begin
         done_d = (q == tgt_q);
         mis_d  = (q != tgt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         j_q    <= '0;
         k_q    <= '0;
         tgt_q  <= '0;
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         j_q    <= j_d;
         k_q    <= k_d;
         tgt_q  <= tgt_d;
         done_q <= done_d;
         mis_q  <= mis_d;
         cnt_q  <= cnt_d;
      end
   end

   assign j_out    = j_q;
   assign k_out    = k_q;
   assign done     = done_q;
   assign mismatch = mis_q;
   assign chg_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_excitation_driver
// Description : Directed self-checking bench for jk_excitation_driver.
//               Instance A: W=4, CW=8.
//               Instance B: W=4, CW=2, used to exercise counter saturation.
//               Expected J/K values follow JK_TOGGLE_EXCITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_excitation_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_valid, b_valid;
   logic [3:0] a_data, b_data;
   logic       a_ready, b_ready;
   logic [3:0] a_j, a_k, a_q, a_qb;
   logic [3:0] b_j, b_k, b_q, b_qb;
   logic       a_done, a_mis, b_done, b_mis;
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jk_excitation_driver #(.W(4), .CW(8)) dut_a (
      .clk(clk), .rst(rst), .tgt_valid(a_valid), .tgt_ready(a_ready),
      .tgt_data(a_data), .j_out(a_j), .k_out(a_k), .q(a_q), .q_bar(a_qb),
      .done(a_done), .mismatch(a_mis), .chg_cnt(a_cnt)
   );

   jk_excitation_driver #(.W(4), .CW(2)) dut_b (
      .clk(clk), .rst(rst), .tgt_valid(b_valid), .tgt_ready(b_ready),
      .tgt_data(b_data), .j_out(b_j), .k_out(b_k), .q(b_q), .q_bar(b_qb),
      .done(b_done), .mismatch(b_mis), .chg_cnt(b_cnt)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One instance-B transaction: handshake, EXCITE, CHECK, done.
   task automatic txn_b(input logic [3:0] tgt, input logic [3:0] ej, input logic [3:0] ek);
      b_valid = 1'b1;
      b_data  = tgt;
      step();
      b_valid = 1'b0;
      chk("b_j", 8'(b_j), 8'(ej));
      chk("b_k", 8'(b_k), 8'(ek));
      step();
      chk("b_q", 8'(b_q), 8'(tgt));
      chk("b_cnt_sat", 8'(b_cnt), 8'h3);
      step();
      chk("b_done", 8'(b_done), 8'h1);
      chk("b_mis", 8'(b_mis), 8'h0);
   endtask

`ifdef JK_TOGGLE_EXCITE_EN
   localparam logic [3:0] EJ1 = 4'b1010, EK1 = 4'b1010;   // 1111 -> 0101
   localparam logic [3:0] EJ3 = 4'b0110, EK3 = 4'b0110;   // 0101 -> 0011
   localparam logic [3:0] EJ4 = 4'b1010, EK4 = 4'b1010;   // 0011 -> 1001
   localparam logic [3:0] EJ5 = 4'b1001, EK5 = 4'b1001;   // 1001 -> 0000
   localparam logic [3:0] EJ0 = 4'b1111, EK0 = 4'b1111;   // 1111 -> 0000
   localparam logic [3:0] EJF = 4'b1111, EKF = 4'b1111;   // 0000 -> 1111
`else
   localparam logic [3:0] EJ1 = 4'b0000, EK1 = 4'b1010;
   localparam logic [3:0] EJ3 = 4'b0010, EK3 = 4'b0100;
   localparam logic [3:0] EJ4 = 4'b1000, EK4 = 4'b0010;
   localparam logic [3:0] EJ5 = 4'b0000, EK5 = 4'b1001;
   localparam logic [3:0] EJ0 = 4'b0000, EK0 = 4'b1111;
   localparam logic [3:0] EJF = 4'b1111, EKF = 4'b0000;
`endif

   initial begin
      rst     = 1'b1;
      a_valid = 1'b0;
      a_data  = 4'h0;
      b_valid = 1'b0;
      b_data  = 4'h0;
      step();
      step();
      rst = 1'b0;

      // ---- reset state ----
      chk("rst_q", 8'(a_q), 8'hF);
      chk("rst_qbar", 8'(a_qb), 8'h0);
      chk("rst_ready", 8'(a_ready), 8'h1);
      chk("rst_cnt", 8'(a_cnt), 8'h0);
      chk("rst_done", 8'(a_done), 8'h0);
      chk("rst_mis", 8'(a_mis), 8'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_j", 8'(a_j), 8'h0);
         chk("idle_k", 8'(a_k), 8'h0);
      end

      // ---- target 0101 from 1111 ----
      a_valid = 1'b1;
      a_data  = 4'b0101;
      step();
      a_valid = 1'b0;
      chk("t1_ready", 8'(a_ready), 8'h0);
      chk("t1_j", 8'(a_j), 8'(EJ1));
      chk("t1_k", 8'(a_k), 8'(EK1));
      chk("t1_q_hold", 8'(a_q), 8'hF);
      step();
      chk("t1_q", 8'(a_q), 8'h5);
      chk("t1_qbar", 8'(a_qb), 8'hA);
      chk("t1_jclr", 8'(a_j), 8'h0);
      chk("t1_kclr", 8'(a_k), 8'h0);
      chk("t1_cnt", 8'(a_cnt), 8'h2);
      chk("t1_done_early", 8'(a_done), 8'h0);
      step();
      chk("t1_done", 8'(a_done), 8'h1);
      chk("t1_mis", 8'(a_mis), 8'h0);
      chk("t1_ready_back", 8'(a_ready), 8'h1);
      step();
      chk("t1_done_pulse", 8'(a_done), 8'h0);

      // ---- same target again: hold ----
      a_valid = 1'b1;
      a_data  = 4'b0101;
      step();
      a_valid = 1'b0;
      chk("t2_j", 8'(a_j), 8'h0);
      chk("t2_k", 8'(a_k), 8'h0);
      step();
      chk("t2_q", 8'(a_q), 8'h5);
      chk("t2_cnt", 8'(a_cnt), 8'h2);
      step();
      chk("t2_done", 8'(a_done), 8'h1);
      chk("t2_mis", 8'(a_mis), 8'h0);

      // ---- valid held while busy: data ignored ----
      a_valid = 1'b1;
      a_data  = 4'b0011;
      step();
      a_data = 4'b1100;
      chk("t3_ready_ex", 8'(a_ready), 8'h0);
      chk("t3_j", 8'(a_j), 8'(EJ3));
      chk("t3_k", 8'(a_k), 8'(EK3));
      step();
      a_data = 4'b1001;
      chk("t3_ready_ck", 8'(a_ready), 8'h0);
      chk("t3_q", 8'(a_q), 8'h3);
      chk("t3_cnt", 8'(a_cnt), 8'h4);
      step();
      chk("t3_done", 8'(a_done), 8'h1);
      chk("t3_ready_idle", 8'(a_ready), 8'h1);
      chk("t3_q_not_busy_data", 8'(a_q), 8'h3);
      step();
      a_valid = 1'b0;
      chk("t4_j", 8'(a_j), 8'(EJ4));
      chk("t4_k", 8'(a_k), 8'(EK4));
      step();
      chk("t4_q", 8'(a_q), 8'h9);
      chk("t4_cnt", 8'(a_cnt), 8'h6);
      step();
      chk("t4_done", 8'(a_done), 8'h1);

      // ---- reset during EXCITE after target 0000 ----
      a_valid = 1'b1;
      a_data  = 4'b0000;
      step();
      a_valid = 1'b0;
      chk("t5_j", 8'(a_j), 8'(EJ5));
      chk("t5_k", 8'(a_k), 8'(EK5));
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_q_rst", 8'(a_q), 8'hF);
      chk("t5_qbar_rst", 8'(a_qb), 8'h0);
      chk("t5_done_rst", 8'(a_done), 8'h0);
      chk("t5_mis_rst", 8'(a_mis), 8'h0);
      chk("t5_cnt_rst", 8'(a_cnt), 8'h0);
      chk("t5_j_rst", 8'(a_j), 8'h0);
      chk("t5_k_rst", 8'(a_k), 8'h0);
      step();
      chk("t5_ready", 8'(a_ready), 8'h1);
      chk("t5_done_after", 8'(a_done), 8'h0);
      chk("t5_mis_after", 8'(a_mis), 8'h0);
      chk("t5_q_after", 8'(a_q), 8'hF);
      step();
      chk("t5_done_after2", 8'(a_done), 8'h0);
      chk("t5_mis_after2", 8'(a_mis), 8'h0);

      // ---- CW=2 instance: alternating full-width changes saturate at 3 ----
      chk("b_rst_cnt", 8'(b_cnt), 8'h0);
      chk("b_rst_q", 8'(b_q), 8'hF);
      txn_b(4'b0000, EJ0, EK0);
      txn_b(4'b1111, EJF, EKF);
      txn_b(4'b0000, EJ0, EK0);
      txn_b(4'b1111, EJF, EKF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
